// File: rtl/rate_divided_hex_counter_pkg.sv
// Shared constants and helpers for the rate-divided hex counter.
// HEX_COUNTER_BCD_EN selects a decimal (0..9) digit instead of full hex.
package hex_counter_pkg;

   localparam logic [1:0] RATE_FULL = 2'b00;
   localparam logic [1:0] RATE_1S   = 2'b01;
   localparam logic [1:0] RATE_2S   = 2'b10;
   localparam logic [1:0] RATE_4S   = 2'b11;

`ifdef HEX_COUNTER_BCD_EN
   localparam logic [3:0] DIGIT_TERM = 4'd9;
`else
   localparam logic [3:0] DIGIT_TERM = 4'hF;
`endif

   // Divider reload value: one less than the tick period for the selected rate.
   function automatic longint unsigned period_m1(input logic [1:0] rate,
                                                 input longint unsigned clk_hz);
      longint unsigned val;
      case (rate)
         RATE_FULL: val = 64'd0;
         RATE_1S:   val = clk_hz - 64'd1;
         RATE_2S:   val = 64'd2 * clk_hz - 64'd1;
         default:   val = 64'd4 * clk_hz - 64'd1;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/rate_divided_hex_counter_if.sv
// Control/digit bundle between the counter and its driver.
interface rate_divided_hex_counter_if;
   logic       enable;
   logic [1:0] sel;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] digit;
   logic       tick;
   logic       wrap;

   modport master (
      output enable, sel, load, load_val,
      input  digit, tick, wrap
   );

   modport slave (
      input  enable, sel, load, load_val,
      output digit, tick, wrap
   );
endinterface

// File: rtl/rate_divided_hex_counter_rate_divider.sv
// Programmable down-counter producing a one-cycle enable tick.
module rate_divider
   import hex_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned DIV_W  = 28
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] sel,
   input  logic       restart,
   output logic       tick
);

   localparam longint unsigned MaxReload = 64'd4 * 64'(CLK_HZ) - 64'd1;

   if ((MaxReload >> DIV_W) != 64'd0) begin : g_width_check
      $error("DIV_W too narrow to hold 4*CLK_HZ-1");
   end

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] reload;

   // sel only matters here, so it is sampled solely on tick or restart.
   assign reload = DIV_W'(period_m1(sel, 64'(CLK_HZ)));
   assign tick   = enable & ~restart & (div_cnt == '0);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (restart || tick) begin
         div_cnt <= reload;
      end else if (enable) begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/rate_divided_hex_counter.sv
// Digit source for the 7-segment decoder: rate divider plus 4-bit counter.
// HEX_COUNTER_BCD_EN limits the digit to 0..9.
module rate_divided_hex_counter
   import hex_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned DIV_W  = 28
) (
   input logic                        CLOCK_50,
   input logic                        reset,
   rate_divided_hex_counter_if.slave  bus
);

   logic       tick;
   logic [3:0] digit;
   logic [3:0] load_digit;

   rate_divider #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W)
   ) u_div (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .enable   (bus.enable),
      .sel      (bus.sel),
      .restart  (bus.load),
      .tick     (tick)
   );

`ifdef HEX_COUNTER_BCD_EN
   assign load_digit = (bus.load_val > 4'd9) ? 4'd0 : bus.load_val;
`else
   assign load_digit = bus.load_val;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         digit <= 4'd0;
      end else if (bus.load) begin
         digit <= load_digit;
      end else if (tick) begin
         digit <= (digit == DIGIT_TERM) ? 4'd0 : digit + 4'd1;
      end
   end

   assign bus.digit = digit;
   assign bus.tick  = tick;
   assign bus.wrap  = tick & (digit == DIGIT_TERM);

endmodule

// File: tb/tb_rate_divided_hex_counter.sv
// Directed bench for rate_divided_hex_counter with a cycle-level reference model.
module tb_rate_divided_hex_counter;
   import hex_counter_pkg::*;

   localparam int unsigned CLK_HZ = 4;
   localparam int unsigned DIV_W  = 5;
`ifdef HEX_COUNTER_BCD_EN
   localparam int TERM = 9;
   localparam bit BCD  = 1'b1;
`else
   localparam int TERM = 15;
   localparam bit BCD  = 1'b0;
`endif

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;

   rate_divided_hex_counter_if bus ();

   rate_divided_hex_counter #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: elapsed enabled cycles within the current interval and its length.
   int m_el    = 0;
   int m_per   = 1;
   int m_digit = 0;

   function automatic int period(input logic [1:0] s);
      if (s == 2'b00) return 1;
      return int'(CLK_HZ) * (1 << (int'(s) - 1));
   endfunction

   function automatic int next_digit(input int d);
      return (d == TERM) ? 0 : d + 1;
   endfunction

   function automatic int clean(input int v);
      return (BCD && v > 9) ? 0 : v;
   endfunction

   always @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         m_el    <= 0;
         m_per   <= 1;
         m_digit <= 0;
      end else if (bus.load) begin
         m_digit <= clean(int'(bus.load_val));
         m_el    <= 0;
         m_per   <= period(bus.sel);
      end else if (bus.enable) begin
         if (m_el == m_per - 1) begin
            m_digit <= next_digit(m_digit);
            m_el    <= 0;
            m_per   <= period(bus.sel);
         end else begin
            m_el <= m_el + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input int exp);
      n_tests++;
      if (got !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_compare();
      int exp_tick;
      exp_tick = (bus.enable && !bus.load && (m_el == m_per - 1)) ? 1 : 0;
      chk("model_tick", 32'(bus.tick), exp_tick);
      chk("model_wrap", 32'(bus.wrap), (exp_tick == 1 && m_digit == TERM) ? 1 : 0);
      chk("model_digit", 32'(bus.digit), m_digit);
      chk("model_div_cnt", 32'(dut.u_div.div_cnt), m_per - 1 - m_el);
   endtask

   // Compare the finished cycle at the falling edge, then land just past the next rising edge.
   task automatic step();
      @(negedge CLOCK_50);
      if (!reset) model_compare();
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      bus.enable   = 1'b0;
      bus.sel      = RATE_1S;
      bus.load     = 1'b0;
      bus.load_val = 4'd0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_digit", 32'(bus.digit), 0);
      chk("rst_div_cnt", 32'(dut.u_div.div_cnt), 0);
      chk("rst_tick_disabled", 32'(bus.tick), 0);
      chk("rst_wrap", 32'(bus.wrap), 0);
      bus.enable = 1'b1;
      #1;
      chk("rst_tick_enabled", 32'(bus.tick), 1);

      // sel=01: ticks at enabled cycles 0,4,8,12.
      for (int i = 0; i <= 13; i++) begin
         if (i > 0) step();
         #1;
         chk("t1_tick", 32'(bus.tick), (i % 4 == 0) ? 1 : 0);
         chk("t1_digit", 32'(bus.digit), (i + 3) / 4);
      end
      chk("t1_digit_after_12", 32'(bus.digit), 4);

      // sel=00 from digit 0: increment every clock through the wrap.
      step();
      bus.load     = 1'b1;
      bus.load_val = 4'd0;
      bus.sel      = RATE_FULL;
      #1;
      chk("t2_load_no_tick", 32'(bus.tick), 0);
      step();
      bus.load = 1'b0;
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) step();
         #1;
         chk("t2_digit", 32'(bus.digit), k % (TERM + 1));
         chk("t2_wrap", 32'(bus.wrap), (k % (TERM + 1) == TERM) ? 1 : 0);
      end
      chk("t2_digit_17", 32'(bus.digit), BCD ? 7 : 1);

      // sel=10: freeze at div_cnt=5 while enable is low.
      step();
      bus.load = 1'b1;
      bus.sel  = RATE_2S;
      step();
      bus.load = 1'b0;
      #1;
      chk("t3_div7", 32'(dut.u_div.div_cnt), 7);
      step();
      #1;
      chk("t3_div6", 32'(dut.u_div.div_cnt), 6);
      step();
      #1;
      chk("t3_div5", 32'(dut.u_div.div_cnt), 5);
      bus.enable = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) step();
         #1;
         chk("t3_hold_div", 32'(dut.u_div.div_cnt), 5);
         chk("t3_hold_tick", 32'(bus.tick), 0);
         chk("t3_hold_digit", 32'(bus.digit), 0);
      end
      step();
      bus.enable = 1'b1;
      #1;
      chk("t3_resume_div5", 32'(dut.u_div.div_cnt), 5);
      step();
      #1;
      chk("t3_resume_div4", 32'(dut.u_div.div_cnt), 4);

      // sel=11: load C mid-interval, next tick 16 enabled cycles later.
      bus.sel = RATE_4S;
      step();
      step();
      bus.load     = 1'b1;
      bus.load_val = 4'hC;
      #1;
      chk("t4_load_no_tick", 32'(bus.tick), 0);
      step();
      bus.load = 1'b0;
      #1;
      chk("t4_loaded_digit", 32'(bus.digit), BCD ? 0 : 12);
      chk("t4_loaded_div", 32'(dut.u_div.div_cnt), 15);
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) step();
         #1;
         chk("t4_tick", 32'(bus.tick), (k == 16) ? 1 : 0);
      end
      step();
      #1;
      chk("t4_digit_after", 32'(bus.digit), BCD ? 1 : 13);

      // sel 11->00 mid-interval: old spacing finishes, then every cycle.
      repeat (4) step();
      bus.sel = RATE_FULL;
      for (int c = 5; c <= 20; c++) begin
         if (c > 5) step();
         #1;
         chk("t5_tick", 32'(bus.tick), (c >= 16) ? 1 : 0);
      end

      // Asynchronous reset between edges with digit=7.
      step();
      bus.load     = 1'b1;
      bus.load_val = 4'd7;
      bus.sel      = RATE_1S;
      step();
      bus.load = 1'b0;
      #1;
      chk("t6_digit7", 32'(bus.digit), 7);
      step();
      #1;
      reset = 1'b1;
      #1;
      chk("t6_rst_digit", 32'(bus.digit), 0);
      chk("t6_rst_div", 32'(dut.u_div.div_cnt), 0);
      #1;
      reset = 1'b0;
      #1;
      chk("t6_first_tick", 32'(bus.tick), 1);
      chk("t6_first_digit", 32'(bus.digit), 0);
      step();
      #1;
      chk("t6_digit_after", 32'(bus.digit), 1);
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
